instr_reg_sched: RTL and testbench
==================================

Name: instr_reg_sched

Overview:
- Controller and arbiter that runs the instruction register as a circular instruction queue.
- Two producers share the register's single write port under round-robin arbitration. One consumer drains entries in order.
- Owns load_en, write_pointer, read_pointer and the write data bus of the instruction register. After reset or flush it sweeps all entries to a known ZERO instruction before accepting traffic.

Parameters:
- DEPTH, 32, number of entries in the instruction register; power of two.
- AW, 5, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  one-cycle pulse; discards queue contents and re-sweeps.
- req0_valid  in  1  producer 0 has an instruction.
- req0_opcode  in  opcode_t  producer 0 opcode.
- req0_operand_a  in  operand_t  producer 0 operand A.
- req0_operand_b  in  operand_t  producer 0 operand B.
- req0_ready  out  1  producer 0 accepted this cycle when valid and ready.
- req1_valid, req1_opcode, req1_operand_a, req1_operand_b, req1_ready  same as producer 0.
- rd_valid  out  1  head entry available on the register's instruction_word.
- rd_ready  in  1  consumer takes the head entry this cycle.
- load_en  out  1  write strobe to the instruction register.
- write_pointer  out  AW  write address.
- read_pointer  out  AW  read address, always equal to head.
- opcode  out  opcode_t  write data.
- operand_a  out  operand_t  write data.
- operand_b  out  operand_t  write data.
- count  out  AW+1  occupancy, 0..DEPTH.
- busy  out  1  high while sweeping.

Behaviour:
- States: INIT (sweep), RUN.
- Reset (sync, high), all outputs registered or derived from registered state:
  - state=INIT, sweep index=0, head=0, tail=0, count=0, rr_last=1 (so req0 wins first).
  - load_en=1, opcode=ZERO, operands=0, busy=1, rd_valid=0, both ready=0.
- INIT:
  - Each cycle, write_pointer=sweep index, load_en=1, data=ZERO/0/0; index increments.
  - After writing index DEPTH-1 (DEPTH cycles), go to RUN with head=tail=0 and count=0. busy deasserts the same edge.
  - Requests and rd_ready are ignored. rd_valid=0 and both ready=0.
- RUN, write side:
  - full = (count==DEPTH).
  - Grant is combinational. If not full and only one valid, that requester is granted. If both valid, grant the one not equal to rr_last.
  - rr_last updates only on a grant.
  - reqX_ready=1 only for the granted requester. Ready never depends on the requester's own valid except through arbitration.
  - On grant: load_en=1, write_pointer=tail, data=granted requester's fields; tail increments modulo DEPTH at the edge.
  - No grant: load_en=0, data buses hold their last value.
- RUN, read side:
  - rd_valid = (count!=0); read_pointer=head.
  - Data written at edge N is readable from cycle N+1; a write never bypasses to the read side in the same cycle.
  - rd_valid && rd_ready: head increments modulo DEPTH.
- Count:
  - +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - Simultaneous write and read while full: the write is blocked (ready=0), so only the read happens and count goes DEPTH-1.
  - At count==1, a simultaneous write and read keeps count=1.
- Pointer wrap: tail/head DEPTH-1 -> 0. Full vs empty is distinguished by count only.
- flush in RUN: next state INIT, sweep index=0, count=0, head=tail=0. Any same-cycle grant or read is suppressed (ready=0 and no pointer change that cycle).
- flush in INIT restarts the sweep at index 0.
- reset overrides flush and all traffic, including mid-sweep.
- A requester holding valid while not granted must hold its data stable. The block does not check this.

Decomposition:
- instr_register_pkg:
  - reuses opcode_t, operand_t, address_t, instruction_t.
  - adds sched_state_t enum {INIT, RUN}.
  - adds DEPTH constant shared with the instruction register.
- Sub-module rr_arb2 (two-way round-robin arbiter: valid[1:0], rr_last in, grant[1:0] out) is natural and is tested standalone.
- Everything else stays in instr_reg_sched.

Test Plan:
- Sweep: pulse reset 1 cycle -> busy=1 for exactly 32 cycles, load_en=1 with write_pointer 0..31 and opcode ZERO; then busy=0, count=0, rd_valid=0.
- Single producer: req0 writes ADD a=5 b=3 then SUB a=9 b=2 -> writes at pointers 0,1, count=2. Consumer with rd_ready=1 sees instruction_word ADD/5/3 then SUB/9/2 on read_pointer 0,1; count returns to 0.
- Contention: both valid continuously for 6 cycles, no reads -> grants alternate req0,req1,req0,req1,req0,req1; tail=6.
- Full/wrap: fill 32 entries -> count=32, both ready=0. One read plus a pending req1 -> the next cycle writes pointer 0 and count returns to 32. Then drain all 32 -> head wraps 31->0.
- Simultaneous: count=1, write and read in the same cycle -> count stays 1, head and tail both advance.
- Flush mid-run: count=7, flush with req0 valid -> no grant that cycle, busy=1 for 32 cycles, count=0 afterwards. Reset asserted at sweep index 10 restarts the sweep at 0.

Source files
------------

// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared types for the instruction register and its scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [AW-1:0]      address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; rr_last names the previous winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_reg_sched.sv
`default_nettype none
// ============================================================================
// Module      : instr_reg_sched
// Description : Runs the instruction register as a circular queue with two
//               round-robin producers, one in-order consumer and a zero sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_reg_sched
    import instr_register_pkg::*;
#(
    parameter int DEPTH = instr_register_pkg::DEPTH,
    parameter int AW    = instr_register_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          req0_valid,
    input  opcode_t       req0_opcode,
    input  operand_t      req0_operand_a,
    input  operand_t      req0_operand_b,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  opcode_t       req1_opcode,
    input  operand_t      req1_operand_a,
    input  operand_t      req1_operand_b,
    output logic          req1_ready,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          load_en,
    output logic [AW-1:0] write_pointer,
    output logic [AW-1:0] read_pointer,
    output opcode_t       opcode,
    output operand_t      operand_a,
    output operand_t      operand_b,
    output logic [AW:0]   count,
    output logic          busy
);

    localparam logic [AW:0]   c_full     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

    sched_state_t  r_state;
    sched_state_t  w_state_next;
    logic [AW-1:0] r_sweep_idx;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_rr_last;
    instruction_t  r_hold;

    logic          w_run_ok;
    logic          w_full;
    logic [1:0]    w_arb_valid;
    logic [1:0]    w_grant;
    logic          w_wr;
    logic          w_rd;
    instruction_t  w_req0;
    instruction_t  w_req1;
    instruction_t  w_wdata;
    instruction_t  w_bus;

    // A flush cycle takes no traffic on either side.
    assign w_run_ok    = (r_state == RUN) && !flush;
    assign w_full      = (r_count == c_full);
    assign w_arb_valid = {req1_valid, req0_valid} & {2{w_run_ok && !w_full}};

    rr_arb2 u_arb (
        .valid   (w_arb_valid),
        .rr_last (r_rr_last),
        .grant   (w_grant)
    );

    assign w_req0  = '{opc: req0_opcode, op_a: req0_operand_a, op_b: req0_operand_b};
    assign w_req1  = '{opc: req1_opcode, op_a: req1_operand_a, op_b: req1_operand_b};
    assign w_wr    = |w_grant;
    assign w_rd    = w_run_ok && (r_count != '0) && rd_ready;
    assign w_wdata = w_grant[1] ? w_req1 : w_req0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT;
            r_sweep_idx <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rr_last   <= 1'b1;
            r_hold      <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_sweep_idx <= '0;
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
            end else if (r_state == INIT) begin
                r_sweep_idx <= r_sweep_idx + AW'(1);
                r_hold      <= '0;
            end else begin
                if (w_wr) begin
                    r_tail    <= r_tail + AW'(1);
                    r_rr_last <= w_grant[1];
                    r_hold    <= w_wdata;
                end
                if (w_rd) begin
                    r_head <= r_head + AW'(1);
                end
                case ({w_wr, w_rd})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT:    w_state_next = (!flush && r_sweep_idx == c_last_idx) ? RUN : INIT;
            RUN:     w_state_next = flush ? INIT : RUN;
            default: w_state_next = INIT;
        endcase
    end

    // Idle cycles in RUN keep the last written word on the bus.
    always_comb begin
        busy          = (r_state == INIT);
        load_en       = (r_state == INIT) || w_wr;
        write_pointer = (r_state == INIT) ? r_sweep_idx : r_tail;
        read_pointer  = r_head;
        rd_valid      = (r_state == RUN) && (r_count != '0);
        req0_ready    = w_grant[0];
        req1_ready    = w_grant[1];
        count         = r_count;
        w_bus         = r_hold;
        if (r_state == INIT) begin
            w_bus = '0;
        end else if (w_wr) begin
            w_bus = w_wdata;
        end
        opcode    = w_bus.opc;
        operand_a = w_bus.op_a;
        operand_b = w_bus.op_b;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_reg_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_reg_sched
// Description : Randomized scoreboard bench for the instruction queue scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_reg_sched;
    import instr_register_pkg::*;

    localparam int N = 32;

    logic     clk = 1'b0;
    logic     reset, flush;
    logic     req0_valid, req1_valid, req0_ready, req1_ready;
    opcode_t  req0_opcode, req1_opcode, opcode;
    operand_t req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
    operand_t operand_a, operand_b;
    logic     rd_valid, rd_ready, load_en, busy;
    logic [4:0] write_pointer, read_pointer;
    logic [5:0] count;

    always #5 clk = ~clk;

    instr_reg_sched #(.DEPTH(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req0_valid(req0_valid), .req0_opcode(req0_opcode),
        .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_opcode(req1_opcode),
        .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b), .req1_ready(req1_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .load_en(load_en),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .count(count), .busy(busy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Reference model: sweep position (-1 once running), occupancy, pointers,
    // last winner, expected read order and the register contents.
    instruction_t exp_q[$];
    instruction_t mem[N];
    instruction_t m_exp, m_got;
    int  m_sw, m_cnt, m_head, m_tail, m_last, m_g;
    bit  m_valid = 1'b0;
    bit  m_wr, m_rd;

    always @(negedge clk) begin
        if (m_valid) begin
            if (m_sw >= 0) begin
                chk("sweep_busy", busy, 1);
                chk("sweep_load_en", load_en, 1);
                chk("sweep_ptr", write_pointer, m_sw);
                chk("sweep_data", {opcode, operand_a, operand_b}, 0);
                chk("sweep_ready", {req1_ready, req0_ready}, 0);
                chk("sweep_rd_valid", rd_valid, 0);
                chk("sweep_count", count, 0);
                m_g = -1;
            end else begin
                m_g = -1;
                if (!flush && m_cnt < N) begin
                    if (req0_valid && req1_valid) m_g = (m_last == 1) ? 0 : 1;
                    else if (req0_valid)          m_g = 0;
                    else if (req1_valid)          m_g = 1;
                end
                chk("run_busy", busy, 0);
                chk("ready", {req1_ready, req0_ready}, (m_g == 0) ? 2'b01 : (m_g == 1) ? 2'b10 : 2'b00);
                chk("load_en", load_en, m_g >= 0);
                chk("count", count, m_cnt);
                chk("rd_valid", rd_valid, m_cnt != 0);
                chk("read_ptr", read_pointer, m_head);
                if (m_g >= 0) begin
                    m_exp = (m_g == 0) ? '{req0_opcode, req0_operand_a, req0_operand_b}
                                       : '{req1_opcode, req1_operand_a, req1_operand_b};
                    chk("write_ptr", write_pointer, m_tail);
                    chk("write_data", {opcode, operand_a, operand_b}, m_exp);
                    exp_q.push_back(m_exp);
                end
                if (!flush && m_cnt != 0 && rd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_nonempty", 0, 1);
                    end else begin
                        m_got = mem[m_head];
                        chk("read_word", m_got, exp_q.pop_front());
                    end
                end
            end
        end
        if (load_en === 1'b1) mem[write_pointer] = '{opcode, operand_a, operand_b};

        if (reset) begin
            m_sw = 0; m_cnt = 0; m_head = 0; m_tail = 0; m_last = 1;
            exp_q.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (flush) begin
                m_sw = 0; m_cnt = 0; m_head = 0; m_tail = 0;
                exp_q.delete();
            end else if (m_sw >= 0) begin
                m_sw = (m_sw == N - 1) ? -1 : m_sw + 1;
            end else begin
                m_wr = (m_g >= 0);
                m_rd = (m_cnt != 0) && rd_ready;
                if (m_wr) begin
                    m_tail = (m_tail + 1) % N;
                    m_last = m_g;
                end
                if (m_rd) m_head = (m_head + 1) % N;
                m_cnt = m_cnt + int'(m_wr) - int'(m_rd);
            end
        end
    end

    logic [1:0] acc;

    // Called at posedge+1; a producer held valid without acceptance keeps its data.
    task automatic step(input bit v0, input bit v1, input bit rr, input bit fl, input bit rnd);
        if (rnd && (!req0_valid || acc[0])) begin
            req0_opcode    = opcode_t'(4'($urandom_range(1, 7)));
            req0_operand_a = operand_t'($urandom);
            req0_operand_b = operand_t'($urandom);
        end
        if (rnd && (!req1_valid || acc[1])) begin
            req1_opcode    = opcode_t'(4'($urandom_range(1, 7)));
            req1_operand_a = operand_t'($urandom);
            req1_operand_b = operand_t'($urandom);
        end
        req0_valid = v0;
        req1_valid = v1;
        rd_ready   = rr;
        flush      = fl;
        #3;
        acc = {req1_valid && req1_ready, req0_valid && req0_ready};
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; rd_ready = 1'b0; acc = 2'b00;
        req0_valid = 1'b0; req0_opcode = ZERO; req0_operand_a = '0; req0_operand_b = '0;
        req1_valid = 1'b0; req1_opcode = ZERO; req1_operand_a = '0; req1_operand_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (34) step(0, 0, 0, 0, 1);

        // single producer, fixed words
        req0_opcode = ADD; req0_operand_a = 5; req0_operand_b = 3;
        step(1, 0, 0, 0, 0);
        req0_opcode = SUB; req0_operand_a = 9; req0_operand_b = 2;
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 1);

        // contention, then fill to full and beyond
        repeat (6) step(1, 1, 0, 0, 1);
        repeat (40) step(1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 1);
        repeat (34) step(0, 0, 1, 0, 1);

        // simultaneous write and read at count 1
        step(1, 0, 0, 0, 1);
        step(1, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);

        // flush at count 7 with req0 pending, then reset mid-sweep
        repeat (7) step(1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1);
        repeat (10) step(0, 0, 0, 0, 1);
        reset = 1'b1;
        step(0, 0, 0, 0, 1);
        reset = 1'b0;
        repeat (34) step(0, 0, 0, 0, 1);

        // random traffic with rare flushes
        repeat (600) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0), 1);
        end
        repeat (40) step(0, 0, 1, 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
